// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source mask, edge/level mode, polarity and routing onto six CPU lines.
// Define IRQ_SYNC_EN to pass src_i through a 2-flop synchroniser (asynchronous sources).
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               ce,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [3:0]         sel,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [5:0]         int_o
);

  localparam logic [15:0] VALID = 16'((32'd1 << NUM_SRC) - 32'd1);

  function automatic logic [31:0] route_valid(input int base);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 8; k++)
      if (base + k < NUM_SRC) m[4*k +: 4] = 4'hF;
    return m;
  endfunction

  localparam logic [31:0] R0_VALID = route_valid(0);
  localparam logic [31:0] R1_VALID = route_valid(8);

  logic [15:0] pending, mask, mode, pol, prev;
  logic [31:0] route0, route1;
  logic        pol_wr_d;
  logic [15:0] src_ext, samp, s, rise, w1c, pend_nxt, active;
  logic [31:0] be;
  logic [2:0]  off;
  logic        wr;
  logic [5:0]  int_nxt;
  logic [63:0] rt;
  logic        unused_addr;

  assign unused_addr = ^{addr[31:5], addr[1:0]};

  always_comb begin
    src_ext = '0;
    src_ext[NUM_SRC-1:0] = src_i;
  end

  assign wr  = ce & we;
  assign off = addr[4:2];
  assign be  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

`ifdef IRQ_SYNC_EN
  logic [15:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src_ext;
      sync2 <= sync1;
    end
  end
  assign samp = sync2;
`else
  assign samp = src_ext;
`endif

  // A polarity change flips s without any real input activity; suppress that cycle's rise.
  assign s    = samp ^ pol;
  assign rise = pol_wr_d ? 16'h0 : (s & ~prev);
  assign w1c  = (wr && off == 3'd0) ? (data_i[15:0] & be[15:0] & VALID) : 16'h0;

  assign pend_nxt = ((mode & ((pending & ~w1c) | rise)) | (~mode & s)) & VALID;
  assign active   = pending & mask;
  assign rt       = {route1, route0};

  always_comb begin
    int_nxt = '0;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 6; k++)
        if (active[i] && rt[4*i +: 4] == 4'(k)) int_nxt[k] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      mask     <= '0;
      mode     <= '0;
      pol      <= '0;
      route0   <= '0;
      route1   <= '0;
      prev     <= '0;
      pol_wr_d <= 1'b0;
      int_o    <= '0;
    end else begin
      pending  <= pend_nxt;
      prev     <= s;
      int_o    <= int_nxt;
      pol_wr_d <= wr && off == 3'd3;
      if (wr) begin
        case (off)
          3'd1: mask   <= ((mask & ~be[15:0]) | (data_i[15:0] & be[15:0])) & VALID;
          3'd2: mode   <= ((mode & ~be[15:0]) | (data_i[15:0] & be[15:0])) & VALID;
          3'd3: pol    <= ((pol  & ~be[15:0]) | (data_i[15:0] & be[15:0])) & VALID;
          3'd4: route0 <= ((route0 & ~be) | (data_i & be)) & R0_VALID;
          3'd5: route1 <= ((route1 & ~be) | (data_i & be)) & R1_VALID;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      case (off)
        3'd0: data_o = {16'h0, pending};
        3'd1: data_o = {16'h0, mask};
        3'd2: data_o = {16'h0, mode};
        3'd3: data_o = {16'h0, pol};
        3'd4: data_o = route0;
        3'd5: data_o = route1;
        3'd6: data_o = {16'h0, s};
        default: data_o = {16'h0, active};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default build, no input synchroniser, NUM_SRC = 8).
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src_i;
  logic        ce, we;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;
  logic [5:0]  int_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_PEND = 32'h00, A_MASK = 32'h04, A_MODE = 32'h08, A_POL = 32'h0C,
                          A_RT0 = 32'h10, A_RT1 = 32'h14, A_RAW = 32'h18, A_ACT = 32'h1C;

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .src_i(src_i), .ce(ce), .we(we), .addr(addr),
    .sel(sel), .data_i(data_i), .data_o(data_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic chk_rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    check(tag, data_o, exp);
    ce = 1'b0;
  endtask

  task automatic chk_int(input logic [5:0] exp, input string tag);
    check(tag, {26'h0, int_o}, {26'h0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; src_i = '0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
    #12;
    chk_int(6'h00, "reset_int");
    for (int i = 0; i < 8; i++) chk_rd(32'(i * 4), 32'h0, "reset_reg");
    step(1);
    rst = 1'b0;
    step(2);
    chk_rd(A_PEND, 32'h0, "idle_pend");

    // register map and byte lanes
    wr(A_MASK, 32'hFFFF_FFFF, 4'hF);
    chk_rd(A_MASK, 32'h0000_00FF, "mask_full");
    chk_rd(A_MASK + 32'h20, 32'h0000_00FF, "mask_alias");
    wr(A_MASK, 32'h0000_005A, 4'b0001);
    chk_rd(A_MASK, 32'h0000_005A, "mask_lane0");
    wr(A_MASK, 32'hFFFF_FFFF, 4'b0010);
    chk_rd(A_MASK, 32'h0000_005A, "mask_lane1_nosrc");
    wr(A_RT1, 32'hFFFF_FFFF, 4'hF);
    chk_rd(A_RT1, 32'h0, "route1_nosrc");

    // level source 0 -> line 0
    wr(A_MASK, 32'h1, 4'hF);
    src_i[0] = 1'b1;
    step(1);
    chk_int(6'h00, "lvl_int_e1");
    chk_rd(A_PEND, 32'h1, "lvl_pend_e1");
    step(1);
    chk_int(6'h01, "lvl_int_e2");
    wr(A_PEND, 32'h1, 4'hF);
    chk_rd(A_PEND, 32'h1, "lvl_w1c_noeffect");
    chk_int(6'h01, "lvl_int_held");
    src_i[0] = 1'b0;
    step(1);
    chk_int(6'h01, "lvl_drop_e1");
    chk_rd(A_PEND, 32'h0, "lvl_drop_pend");
    step(1);
    chk_int(6'h00, "lvl_drop_e2");

    // edge source 1 -> line 3
    wr(A_MODE, 32'h2, 4'hF);
    wr(A_MASK, 32'h2, 4'hF);
    wr(A_RT0, 32'h30, 4'hF);
    src_i[1] = 1'b1;
    step(1);
    src_i[1] = 1'b0;
    chk_rd(A_PEND, 32'h2, "edge_pend");
    chk_int(6'h00, "edge_int_e1");
    step(1);
    chk_int(6'h08, "edge_int_e2");
    step(2);
    chk_int(6'h08, "edge_int_held");
    chk_rd(A_PEND, 32'h2, "edge_pend_held");
    chk_rd(A_ACT, 32'h2, "edge_active");
    wr(A_PEND, 32'h2, 4'hF);
    chk_rd(A_PEND, 32'h0, "w1c_pend");
    chk_int(6'h08, "w1c_int_N");
    step(1);
    chk_int(6'h00, "w1c_int_N1");

    // set and clear in the same cycle: set wins
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = A_PEND; data_i = 32'h2; sel = 4'hF;
    src_i[1] = 1'b1;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
    src_i[1] = 1'b0;
    chk_rd(A_PEND, 32'h2, "set_wins");
    wr(A_PEND, 32'h2, 4'hF);
    chk_rd(A_PEND, 32'h0, "set_wins_cleanup");

    // source 2 (level) unrouted, then routed to line 5
    wr(A_RT0, 32'h730, 4'hF);
    wr(A_MASK, 32'h6, 4'hF);
    src_i[2] = 1'b1;
    step(2);
    chk_int(6'h00, "unrouted_int");
    chk_rd(A_ACT, 32'h4, "unrouted_active");
    chk_rd(A_RAW, 32'h4, "raw_src2");
    wr(A_RT0, 32'h530, 4'hF);
    chk_int(6'h00, "route_wr_N");
    step(1);
    chk_int(6'h20, "route_wr_N1");
    src_i[2] = 1'b0;
    step(2);
    chk_int(6'h00, "route_src_drop");

    // polarity on edge source 3 -> line 1
    wr(A_MODE, 32'hA, 4'hF);
    wr(A_MASK, 32'h8, 4'hF);
    wr(A_RT0, 32'h1530, 4'hF);
    wr(A_POL, 32'h8, 4'hF);
    chk_rd(A_PEND, 32'h0, "pol_wr_N");
    step(1);
    chk_rd(A_PEND, 32'h0, "pol_no_spurious");
    chk_rd(A_RAW, 32'h8, "pol_raw");
    src_i[3] = 1'b1;
    step(1);
    chk_rd(A_PEND, 32'h0, "pol_src_high");
    src_i[3] = 1'b0;
    step(1);
    chk_rd(A_PEND, 32'h8, "pol_fall_sets");
    step(1);
    chk_int(6'h02, "pol_int");

    // asynchronous reset mid-operation
    #1;
    rst = 1'b1;
    #1;
    chk_int(6'h00, "midrst_int");
    for (int i = 0; i < 8; i++) chk_rd(32'(i * 4), 32'h0, "midrst_reg");
    src_i[0] = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk_rd(A_PEND, 32'h1, "post_rst_sample");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller between peripheral interrupt sources (timer, UART, GPIO, …) and the CPU's 6-bit `int_i` input. It replaces the fixed `{5'b00000, timer_int}` hookup with per-source configuration: mask, edge/level mode, polarity, and routing to any of the six CPU lines. Software configures it as a 32-bit memory-mapped slave on the data bus, using the same ce/we/addr/sel/data signalling as `data_ram`.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src_i`  in  NUM_SRC  raw interrupt request inputs.
- `ce`  in  1  slave select.
- `we`  in  1  write enable, qualified by `ce`.
- `addr`  in  32  byte address. Only `addr[4:2]` is decoded; other bits are ignored, so the register map aliases.
- `sel`  in  4  byte enables for writes; `sel[0]` selects `data_i[7:0]`.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, combinational.
- `int_o`  out  6  registered interrupt lines to the CPU `int_i`.

## Operation
- Source bits at index ≥ NUM_SRC read 0 and ignore writes in every register.
- Register map (word offset, reset value):
  - 0x00 PENDING: read; write-1-to-clear for edge sources; reset 0.
  - 0x04 MASK: read/write, 1 = enabled; reset 0.
  - 0x08 MODE: read/write, 1 = edge, 0 = level; reset 0.
  - 0x0C POLARITY: read/write, 1 = active-low; reset 0.
  - 0x10 ROUTE0: 4-bit fields, sources 0..7, field k in bits [4k+3:4k]; reset 0.
  - 0x14 ROUTE1: sources 8..15; reset 0.
  - 0x18 RAW: read-only, polarity-adjusted sampled level `s`.
  - 0x1C ACTIVE: read-only, PENDING & MASK.
- Route field value 0..5 selects CPU line 0..5. Values 6..15 leave the source unrouted.
- Sampling:
  - `s = sampled(src_i) ^ POLARITY`.
  - `prev` is a register loaded with `s` every cycle.
  - `rise = s & ~prev`.
- Pending update, every cycle:
  - Level source: `PENDING[i] <= s[i]`. W1C has no effect.
  - Edge source: `PENDING[i] <= (PENDING[i] & ~w1c[i]) | rise[i]`. If a set and a clear land in the same cycle, the set wins.
- Output: `int_o[k] <= OR over i of (PENDING[i] & MASK[i] & ROUTE[i]==k)`.
- Writes: on the rising edge when `ce & we`, applied per byte lane using `sel`. Writes to read-only offsets are ignored.
- Reads: `data_o` = addressed register when `ce & ~we`, otherwise 0.
- Changing MODE from level to edge keeps the current PENDING value. Changing edge to level overwrites PENDING with `s` on the next edge.
- A POLARITY write forces `rise = 0` for the following cycle, so no spurious edge is produced. During that cycle `prev` still reloads with the new `s`.

## Timing
- Reset, asynchronous: `int_o` = 0. PENDING, MASK, MODE, POLARITY, ROUTE0/1, `prev` and the synchroniser flops are all 0. `data_o` reflects the reset registers combinationally.
- Latency from `src_i` change to `int_o`, with the source enabled and routed:
  - 2 edges without IRQ_SYNC_EN: PENDING at edge 1, `int_o` at edge 2.
  - 4 edges with IRQ_SYNC_EN.
- Latency from a MASK/ROUTE write (edge N) or a PENDING W1C (edge N) to `int_o` updating: edge N+1.
- A read returns the register value as of the last completed edge, in the same cycle. A write is visible on reads from the following cycle.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion samples `src_i` with `prev` = 0, so an input already asserted and in edge mode registers a rise.

## Configuration
- `IRQ_SYNC_EN` defined: `src_i` passes through a 2-flop synchroniser (reset 0) before forming `s`. Use this when sources are asynchronous, e.g. GPIO pads.
- `IRQ_SYNC_EN` undefined: `src_i` is used directly; sources must be synchronous to `clk`. Latency is reduced by 2 cycles.

## Test plan
- Reset and register map: after reset, read all 8 offsets → 0 and `int_o` = 0. Write 0xFFFFFFFF to MASK with NUM_SRC = 8 → read returns 0x000000FF. Write MASK with `sel` = 4'b0001 and data 0x0000005A → read returns 0x5A.
- Level source:
  - Setup: MASK = 0x01, MODE = 0, ROUTE0 = 0x0, `src_i[0]` rises at edge T.
  - Response: `int_o` = 6'b000001 after 2 edges (4 with IRQ_SYNC_EN).
  - Drop `src_i[0]` → `int_o` returns to 0 with the same latency. W1C of PENDING bit 0 while the source is high → no effect.
- Edge latch and W1C:
  - Setup: MODE = 0x02, MASK = 0x02, ROUTE0 = 0x30 (source 1 → line 3); pulse `src_i[1]` for 1 cycle.
  - Response: PENDING = 0x02 and `int_o` = 6'b001000, held after the pulse ends.
  - Write 0x02 to PENDING → `int_o` = 0 one edge later.
- Simultaneous set and clear: a W1C of bit 1 in the same cycle as a new rise on source 1 → PENDING[1] stays 1.
- Routing and polarity:
  - Source 2 routed to 7 (unrouted), pending and masked → `int_o` = 0, ACTIVE bit 2 = 1.
  - POLARITY bit 3 set while `src_i[3]` = 0 in edge mode → no PENDING set. A subsequent fall of `src_i[3]` from 1 to 0 sets PENDING[3].
- Reset mid-operation: assert `rst` while `int_o` ≠ 0 → `int_o` = 0 and all registers are 0 with no clock edge.
